// File: rtl/multicycle_maindec.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute per opcode
// with Moore control strobes, optional memory wait states and illegal-opcode flagging.
module multicycle_maindec #(
  parameter int OP_W     = 6,
  parameter int MEM_WAIT = 0,
  parameter bit EXT_OPS  = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [OP_W-1:0] op,
  output logic            pcwrite,
  output logic            branch,
  output logic            branch_ne,
  output logic            irwrite,
  output logic            memwrite,
  output logic            regwrite,
  output logic            iord,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      pcsrc,
  output logic            regdst,
  output logic            memtoreg,
  output logic [1:0]      aluop,
  output logic            illegal_op,
  output logic [3:0]      state_o
);

  typedef enum logic [3:0] {
    RST0    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    EXECUTE = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    IMMEX   = 4'd10,
    IMMWB   = 4'd11,
    JUMP    = 4'd12
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] aluop;
  } ctrl_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [3:0]      WAIT_LD  = 4'(MEM_WAIT);

  state_t          state, state_n;
  logic [3:0]      ctr, ctr_n;
  logic [OP_W-1:0] opreg, opreg_n;
  ctrl_t           ctrl_q;

  function automatic logic is_legal(input logic [OP_W-1:0] o);
    case (o)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      OP_BNE, OP_ORI:                                return EXT_OPS;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic ctrl_t decode(input state_t s, input logic [3:0] c,
                                   input logic [OP_W-1:0] o);
    ctrl_t d;
    d = '0;
    case (s)
      FETCH: begin
        d.alusrcb = 2'b01;
        d.irwrite = (c == 4'd0);
        d.pcwrite = (c == 4'd0);
      end
      DECODE:  d.alusrcb = 2'b11;
      MEMADR: begin
        d.alusrca = 1'b1;
        d.alusrcb = 2'b10;
      end
      MEMRD:   d.iord = 1'b1;
      MEMWB: begin
        d.memtoreg = 1'b1;
        d.regwrite = 1'b1;
      end
      MEMWR: begin
        d.iord     = 1'b1;
        d.memwrite = (c == 4'd0);
      end
      EXECUTE: begin
        d.alusrca = 1'b1;
        d.aluop   = 2'b10;
      end
      ALUWB: begin
        d.regdst   = 1'b1;
        d.regwrite = 1'b1;
      end
      BRANCH: begin
        d.alusrca   = 1'b1;
        d.aluop     = 2'b01;
        d.pcsrc     = 2'b01;
        d.branch    = (o == OP_BEQ);
        d.branch_ne = EXT_OPS && (o == OP_BNE);
      end
      IMMEX: begin
        d.alusrca = 1'b1;
        d.alusrcb = 2'b10;
        d.aluop   = (EXT_OPS && (o == OP_ORI)) ? 2'b11 : 2'b00;
      end
      IMMWB:   d.regwrite = 1'b1;
      JUMP: begin
        d.pcsrc   = 2'b10;
        d.pcwrite = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  always_comb begin
    state_n = state;
    ctr_n   = ctr;
    opreg_n = opreg;
    if ((state == FETCH || state == MEMRD || state == MEMWR) && ctr != 4'd0) begin
      ctr_n = ctr - 4'd1;
    end else begin
      case (state)
        RST0:    state_n = FETCH;
        FETCH:   state_n = DECODE;
        DECODE: begin
          opreg_n = op;
          case (op)
            OP_LW, OP_SW: state_n = MEMADR;
            OP_RTYPE:     state_n = EXECUTE;
            OP_BEQ:       state_n = BRANCH;
            OP_BNE:       state_n = EXT_OPS ? BRANCH : FETCH;
            OP_ADDI:      state_n = IMMEX;
            OP_ORI:       state_n = EXT_OPS ? IMMEX : FETCH;
            OP_J:         state_n = JUMP;
            default:      state_n = FETCH;
          endcase
        end
        MEMADR:  state_n = (opreg == OP_LW) ? MEMRD : MEMWR;
        MEMRD:   state_n = MEMWB;
        EXECUTE: state_n = ALUWB;
        IMMEX:   state_n = IMMWB;
        default: state_n = FETCH;
      endcase
      // Every entry into a memory-access state restarts the wait count.
      if (state_n == FETCH || state_n == MEMRD || state_n == MEMWR)
        ctr_n = WAIT_LD;
    end
  end

  // Strobes are registered from the next-state view so they line up with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RST0;
      ctr    <= '0;
      opreg  <= '0;
      ctrl_q <= '0;
    end else begin
      state  <= state_n;
      ctr    <= ctr_n;
      opreg  <= opreg_n;
      ctrl_q <= decode(state_n, ctr_n, opreg_n);
    end
  end

  // The illegal flag depends on the live opcode during DECODE, so it cannot be registered ahead.
  assign illegal_op = (state == DECODE) && !is_legal(op);
  assign state_o    = state;
  assign pcwrite    = ctrl_q.pcwrite;
  assign branch     = ctrl_q.branch;
  assign branch_ne  = ctrl_q.branch_ne;
  assign irwrite    = ctrl_q.irwrite;
  assign memwrite   = ctrl_q.memwrite;
  assign regwrite   = ctrl_q.regwrite;
  assign iord       = ctrl_q.iord;
  assign alusrca    = ctrl_q.alusrca;
  assign alusrcb    = ctrl_q.alusrcb;
  assign pcsrc      = ctrl_q.pcsrc;
  assign regdst     = ctrl_q.regdst;
  assign memtoreg   = ctrl_q.memtoreg;
  assign aluop      = ctrl_q.aluop;

endmodule

// File: tb/tb_multicycle_maindec.sv
// Bench for multicycle_maindec: four configurations run side by side and each cycle is compared
// against a per-instruction cycle sequence generated from the control rules.
module tb_multicycle_maindec;

  localparam int NI = 4;
  localparam int MWS[NI] = '{0, 2, 0, 15};
  localparam bit EXS[NI] = '{1'b1, 1'b1, 1'b0, 1'b1};

  localparam logic [3:0] S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3, S_MEMRD = 4'd4,
                         S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXECUTE = 4'd7, S_ALUWB = 4'd8,
                         S_BRANCH = 4'd9, S_IMMEX = 4'd10, S_IMMWB = 4'd11, S_JUMP = 4'd12;

  localparam logic [5:0] O_R = 6'b000000, O_J = 6'b000010, O_BEQ = 6'b000100,
                         O_BNE = 6'b000101, O_ADDI = 6'b001000, O_ORI = 6'b001101,
                         O_LW = 6'b100011, O_SW = 6'b101011;

  typedef struct packed {
    logic [3:0] st;
    logic       ill;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] aluop;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'd0;
  obs_t       ob[NI];
  obs_t       bq[$];
  obs_t       sq0[$], sq1[$], sq2[$], sq3[$];
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    logic pcwrite, branch, branch_ne, irwrite, memwrite, regwrite, iord, alusrca;
    logic regdst, memtoreg, illegal_op;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state_o;
    multicycle_maindec #(.OP_W(6), .MEM_WAIT(MWS[g]), .EXT_OPS(EXS[g])) u_dut (
      .clk(clk), .reset_n(reset_n), .op(op),
      .pcwrite(pcwrite), .branch(branch), .branch_ne(branch_ne), .irwrite(irwrite),
      .memwrite(memwrite), .regwrite(regwrite), .iord(iord), .alusrca(alusrca),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .regdst(regdst), .memtoreg(memtoreg),
      .aluop(aluop), .illegal_op(illegal_op), .state_o(state_o)
    );
    assign ob[g] = {state_o, illegal_op, pcwrite, branch, branch_ne, irwrite, memwrite,
                    regwrite, iord, alusrca, alusrcb, pcsrc, regdst, memtoreg, aluop};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // 0 illegal, 1 LW, 2 SW, 3 R, 4 BEQ, 5 BNE, 6 ADDI, 7 ORI, 8 J
  function automatic int op_kind(input logic [5:0] o, input bit ext);
    case (o)
      O_LW:    return 1;
      O_SW:    return 2;
      O_R:     return 3;
      O_BEQ:   return 4;
      O_BNE:   return ext ? 5 : 0;
      O_ADDI:  return 6;
      O_ORI:   return ext ? 7 : 0;
      O_J:     return 8;
      default: return 0;
    endcase
  endfunction

  // One instruction, cycle by cycle, from FETCH until the cycle before the next FETCH.
  task automatic build(input int mw, input bit ext, input logic [5:0] o);
    obs_t e;
    int   kind;
    kind = op_kind(o, ext);
    bq.delete();
    for (int i = 0; i <= mw; i++) begin
      e = '0; e.st = S_FETCH; e.alusrcb = 2'b01;
      e.irwrite = (i == mw); e.pcwrite = (i == mw);
      bq.push_back(e);
    end
    e = '0; e.st = S_DECODE; e.alusrcb = 2'b11; e.ill = (kind == 0);
    bq.push_back(e);
    if (kind == 1 || kind == 2) begin
      e = '0; e.st = S_MEMADR; e.alusrca = 1'b1; e.alusrcb = 2'b10;
      bq.push_back(e);
      for (int i = 0; i <= mw; i++) begin
        e = '0; e.iord = 1'b1;
        e.st = (kind == 1) ? S_MEMRD : S_MEMWR;
        e.memwrite = (kind == 2) && (i == mw);
        bq.push_back(e);
      end
      if (kind == 1) begin
        e = '0; e.st = S_MEMWB; e.memtoreg = 1'b1; e.regwrite = 1'b1;
        bq.push_back(e);
      end
    end else if (kind == 3) begin
      e = '0; e.st = S_EXECUTE; e.alusrca = 1'b1; e.aluop = 2'b10;
      bq.push_back(e);
      e = '0; e.st = S_ALUWB; e.regdst = 1'b1; e.regwrite = 1'b1;
      bq.push_back(e);
    end else if (kind == 4 || kind == 5) begin
      e = '0; e.st = S_BRANCH; e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01;
      e.branch = (kind == 4); e.branch_ne = (kind == 5);
      bq.push_back(e);
    end else if (kind == 6 || kind == 7) begin
      e = '0; e.st = S_IMMEX; e.alusrca = 1'b1; e.alusrcb = 2'b10;
      e.aluop = (kind == 7) ? 2'b11 : 2'b00;
      bq.push_back(e);
      e = '0; e.st = S_IMMWB; e.regwrite = 1'b1;
      bq.push_back(e);
    end else if (kind == 8) begin
      e = '0; e.st = S_JUMP; e.pcsrc = 2'b10; e.pcwrite = 1'b1;
      bq.push_back(e);
    end
  endtask

  task automatic load_all(input logic [5:0] o);
    build(MWS[0], EXS[0], o); sq0 = bq;
    build(MWS[1], EXS[1], o); sq1 = bq;
    build(MWS[2], EXS[2], o); sq2 = bq;
    build(MWS[3], EXS[3], o); sq3 = bq;
  endtask

  // Cycle 0 after reset release is RST0 (all zero); the instruction then repeats forever.
  function automatic obs_t expect_at(input int g, input int k);
    if (k == 0) return '0;
    case (g)
      0:       return sq0[(k - 1) % sq0.size()];
      1:       return sq1[(k - 1) % sq1.size()];
      2:       return sq2[(k - 1) % sq2.size()];
      default: return sq3[(k - 1) % sq3.size()];
    endcase
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++)
      check_eq($sformatf("reset_cfg%0d", g), 32'(ob[g]), 32'd0);
    reset_n = 1'b1;
  endtask

  task automatic run(input int n, input logic [NI-1:0] mask, input int chg_k,
                     input logic [5:0] chg_op);
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < NI; g++)
        if (mask[g])
          check_eq($sformatf("cfg%0d_op%b_k%0d", g, op, k), 32'(ob[g]),
                   32'(expect_at(g, k)));
      @(posedge clk);
      #1;
      if (k == chg_k) op = chg_op;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [5:0] legal[8];
    legal = '{O_LW, O_SW, O_R, O_BEQ, O_BNE, O_ADDI, O_ORI, O_J};

    for (int i = 0; i < 8; i++) begin
      op = legal[i];
      load_all(op);
      do_reset();
      run(40, '1, -1, 6'd0);
    end

    // Opcode swapped right after leaving DECODE must not disturb the latched instruction.
    op = O_R;   load_all(op); do_reset(); run(6, 4'b0101, 2, O_J);
    op = O_LW;  load_all(op); do_reset(); run(6, 4'b0101, 2, O_SW);
    op = O_BNE; load_all(op); do_reset(); run(4, 4'b0001, 2, O_BEQ);
    op = O_ORI; load_all(op); do_reset(); run(5, 4'b0001, 2, O_ADDI);

    // Asynchronous reset dropped while an R-type sits in EXECUTE.
    op = O_R; load_all(op); do_reset();
    run(3, '1, -1, 6'd0);
    check_eq("exec_before_reset", 32'(ob[0].st), 32'(S_EXECUTE));
    reset_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++)
      check_eq($sformatf("mid_reset_cfg%0d", g), 32'(ob[g]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run(12, '1, -1, 6'd0);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1) op = legal[$urandom_range(0, 7)];
      else op = 6'($urandom_range(0, 63));
      load_all(op);
      do_reset();
      run(40, '1, -1, 6'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
